// File: rtl/conv_out_serializer.sv
// -----------------------------------------------------------------------------
// conv_out_serializer
//
// Buffers whole result rows from the convolution core and streams each row
// out as a sequence of ready/valid beats of BEAT_WORDS words. The core cannot
// be stalled. A row that arrives while every slot is occupied is dropped, and
// the sticky overflow flag records the loss.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-low reset
//   din        result row, DATA_OF_SET words of DATA_WIDTH bits
//   din_valid  one row per high cycle, no backpressure
//   m_data     output beat, lane j = word k*BEAT_WORDS+j of the row
//   m_valid    m_data is valid (high while any row is buffered)
//   m_ready    downstream accepts the beat
//   m_last     current beat is the final beat of a row
//   rows_out   rows fully transmitted, modulo 2^16
//   overflow   sticky: at least one row was dropped
//   busy       at least one row is buffered
// -----------------------------------------------------------------------------
module conv_out_serializer #(
  parameter int DATA_WIDTH  = 32,
  parameter int DATA_OF_SET = 128,
  parameter int BEAT_WORDS  = 4,
  parameter int ROW_DEPTH   = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] din,
  input  logic                                   din_valid,
  output logic [BEAT_WORDS-1:0][DATA_WIDTH-1:0]  m_data,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic                                   m_last,
  output logic [15:0]                            rows_out,
  output logic                                   overflow,
  output logic                                   busy
);

  localparam int BEATS  = DATA_OF_SET / BEAT_WORDS;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = (ROW_DEPTH > 1) ? $clog2(ROW_DEPTH) : 1;
  localparam int CNT_W  = $clog2(ROW_DEPTH + 1);
  localparam int WORD_W = (DATA_OF_SET > 1) ? $clog2(DATA_OF_SET) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e                                 r_state;
  logic [BEAT_W-1:0]                      r_beat;
  logic [PTR_W-1:0]                       r_wr_ptr;
  logic [PTR_W-1:0]                       r_rd_ptr;
  logic [CNT_W-1:0]                       r_count;
  logic [15:0]                            r_rows_out;
  logic                                   r_overflow;
  logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] r_mem [ROW_DEPTH];

  logic             w_xfer;
  logic             w_beat_last;
  logic             w_final;
  logic             w_capture;
  logic             w_drop;
  logic [CNT_W-1:0] w_count_nxt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ROW_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_xfer      = (r_state == STREAM) && m_ready;
  assign w_beat_last = (r_beat == BEAT_W'(BEATS - 1));
  assign w_final     = w_xfer && w_beat_last;
  // A full buffer still accepts a row on the edge its head row finishes:
  // the freed slot is the one the write pointer already points at.
  assign w_capture   = din_valid && ((r_count < CNT_W'(ROW_DEPTH)) || w_final);
  assign w_drop      = din_valid && !w_capture;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_count_nxt = r_count;
    if (w_capture && !w_final) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_capture && w_final) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // NOTE: row storage is deliberately left out of reset; the pointers and
  // count decide what is valid, and clearing wide storage buys nothing.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the values from before this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_beat     <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rows_out <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_capture) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_xfer) begin
        if (w_beat_last) begin
          r_beat     <= '0;
          r_rd_ptr   <= ptr_inc(r_rd_ptr);
          r_rows_out <= r_rows_out + 16'd1;
        end else begin
          r_beat <= r_beat + 1'b1;
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_nxt;
      // State is kept in step with the next occupancy so m_valid is a flop.
      case (r_state)
        IDLE:    if (w_count_nxt != '0) r_state <= STREAM;
        STREAM:  if (w_count_nxt == '0) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Beat mux: lane j carries word r_beat*BEAT_WORDS+j of the head row.
  always_comb begin
    logic [WORD_W-1:0] v_idx;
    m_data = '0;
    v_idx  = '0;
    if (r_state == STREAM) begin
      for (int j = 0; j < BEAT_WORDS; j++) begin
        v_idx     = WORD_W'(r_beat) * WORD_W'(BEAT_WORDS) + WORD_W'(j);
        m_data[j] = r_mem[r_rd_ptr][v_idx];
      end
    end
  end

  assign m_valid  = (r_state == STREAM);
  assign m_last   = m_valid && w_beat_last;
  assign rows_out = r_rows_out;
  assign overflow = r_overflow;
  assign busy     = (r_count != '0);

endmodule

// File: doc/conv_out_serializer.md
CONV_OUT_SERIALIZER -- requirements
Module: conv_out_serializer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bit width of one output word.
REQ-002 Parameter DATA_OF_SET, default 128: words per result row from the convolution core.
REQ-003 Parameter BEAT_WORDS, default 4: words per output beat; DATA_OF_SET SHALL be an integer multiple of BEAT_WORDS.
REQ-004 Parameter ROW_DEPTH, default 2: number of row slots in the internal buffer; ROW_DEPTH SHALL be at least 1.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 din  input  [DATA_OF_SET][DATA_WIDTH]  result row from the convolution core's dout.
REQ-008 din_valid  input  1  row-valid strobe from the core's dout_valid; one row per high cycle; no backpressure to the core.
REQ-009 m_data  output  [BEAT_WORDS][DATA_WIDTH]  output beat.
REQ-010 m_valid  output  1  m_data is valid.
REQ-011 m_ready  input  1  downstream accepts the beat.
REQ-012 m_last  output  1  current beat is the final beat of a row.
REQ-013 rows_out  output  16  count of rows fully transmitted, modulo 2^16.
REQ-014 overflow  output  1  sticky flag: at least one row was dropped.
REQ-015 busy  output  1  high while any row is buffered.

Function
REQ-016 Beats per row, BEATS, SHALL equal DATA_OF_SET/BEAT_WORDS (32 at defaults); the beat counter SHALL be clog2(BEATS) bits wide.
REQ-017 Handshake: a beat transfers on a rising edge where m_valid and m_ready are both high.
REQ-018 While m_valid is high and m_ready is low, m_data, m_last and the beat index SHALL be held stable.
REQ-019 Beat k of a row SHALL carry words k*BEAT_WORDS+j on lane j, for j = 0..BEAT_WORDS-1.
REQ-020 m_last SHALL be high exactly when m_valid is high and the beat index equals BEATS-1.
REQ-021 The row buffer SHALL be a circular FIFO of ROW_DEPTH slots with a write pointer, a read pointer and an occupancy count; both pointers SHALL wrap from ROW_DEPTH-1 to 0.
REQ-022 Capture: on an edge where din_valid is high and count < ROW_DEPTH, din SHALL be written to the slot at the write pointer, and the write pointer SHALL advance.
REQ-023 Simultaneous write and read: when count == ROW_DEPTH and the final beat of the head row transfers on the same edge as din_valid, the incoming row SHALL be accepted, and count SHALL remain ROW_DEPTH.
REQ-024 Drop: when din_valid is high and no slot is free (see REQ-023), the row SHALL be discarded, overflow SHALL be set to 1, and no other state SHALL change.
REQ-025 The state machine SHALL have two states:
  - IDLE (count == 0): m_valid = 0.
  - STREAM (count > 0): m_valid = 1, and m_data is read from the slot at the read pointer at the current beat index.
REQ-026 Latency: a row captured into an empty buffer on edge N SHALL present beat 0 with m_valid high during the cycle that follows edge N.
REQ-027 On transfer of a non-final beat, the beat index SHALL increment by 1.
REQ-028 On transfer of the final beat:
  - the beat index SHALL return to 0;
  - the read pointer SHALL advance;
  - count SHALL decrement, unless a capture occurs on the same edge;
  - rows_out SHALL increment, wrapping from 0xFFFF to 0.
REQ-029 When rows are buffered back-to-back, beat 0 of the next row SHALL follow the final beat of the previous row with no idle cycle.
REQ-030 busy SHALL equal (count != 0).

Reset
REQ-031 While rst is low, the following SHALL be 0:
  - count, both pointers and the beat index;
  - rows_out and overflow;
  - m_valid, m_last and busy.
REQ-032 m_data SHALL be 0 during reset; row-slot contents need not be cleared.
REQ-033 If reset asserts mid-row, the partial row SHALL be abandoned; after release the block SHALL be in IDLE.
REQ-034 overflow SHALL clear only on reset.

Verification
REQ-035 Reset: hold rst low for 3 cycles -> m_valid=0, m_last=0, busy=0, rows_out=0, overflow=0, m_data=0.
REQ-036 Single row: din[i]=i with din_valid high for 1 cycle, m_ready=1 -> 32 consecutive beats; beat k lanes are 4k..4k+3; m_last high on beat 31 only; rows_out=1; busy=0 afterwards.
REQ-037 Backpressure: same row, with m_ready toggled 1,0,0,1 repeatedly -> no beat lost or duplicated, m_data held while stalled, 32 transfers total.
REQ-038 Overflow: m_ready=0 while rows of all-1, all-2 and all-3 arrive on consecutive cycles -> overflow=1; draining yields the all-1 row then the all-2 row only; rows_out=2.
REQ-039 Simultaneous: buffer full and a new all-7 row arrives on the edge where the head row's beat 31 transfers -> row accepted, overflow stays 0, all-7 row emitted last.
REQ-040 Mid-row reset: assert rst at beat 10 -> m_valid=0 and busy=0 immediately; a new row after release starts from beat 0 with rows_out counting from 0.
